// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - framing definitions shared by the serial transmit and receive paths
package serial_pkg;

    localparam int DATA_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } rx_state_e;

endpackage

// File: rtl/serial_rx_if.sv
// rtl/serial_rx_if.sv - serial line plus word-level valid/ready handshake of the receiver
interface serial_rx_if
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              ena;
    logic              data_in;
    logic              ready;
    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              frame_err;
    logic              overrun;

    modport master (
        output ena, data_in, ready,
        input  data_out, valid, frame_err, overrun
    );

    modport slave (
        input  ena, data_in, ready,
        output data_out, valid, frame_err, overrun
    );
endinterface

// File: rtl/rx_hold.sv
// rtl/rx_hold.sv - valid/ready holding register for received words with overrun pulse
module rx_hold
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] i_word,
    input  logic              i_load,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_overrun
);
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_overrun;
    logic              w_accept;

    // A word fits if the register is empty or is being drained on this same edge.
    assign w_accept = i_load && (!r_valid || i_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_load && !w_accept;
            if (w_accept) begin
                r_data  <= i_word;
                r_valid <= 1'b1;
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/serial_rx.sv
// rtl/serial_rx.sv - start/data/stop frame receiver feeding a valid/ready word register
module serial_rx
    import serial_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_rx_if.slave  bus
);
    localparam int             CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [1:0]     S_IDLE   = IDLE;
    localparam logic [1:0]     S_DATA   = DATA;
    localparam logic [1:0]     S_STOP   = STOP;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_frame_err;
    logic              w_in_stop;
    logic              w_load;
    logic              w_stop_bad;
    logic [DATA_W-1:0] w_data;
    logic              w_valid;
    logic              w_overrun;

    assign w_in_stop  = (r_state == S_STOP) && bus.ena;
    assign w_load     = w_in_stop && bus.data_in;
    assign w_stop_bad = w_in_stop && !bus.data_in;

    // The stop-bit cycle always returns to IDLE, so a bad stop of 0 is never taken as a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_stop_bad;
            case (r_state)
                S_IDLE: begin
                    if (bus.ena && !bus.data_in) begin
                        r_state <= S_DATA;
                        r_cnt   <= '0;
                    end
                end
                S_DATA: begin
                    if (!bus.ena) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_shift <= {r_shift[DATA_W-2:0], bus.data_in};
                        if (r_cnt == CNT_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_STOP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    rx_hold #(.DATA_W(DATA_W)) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_word    (r_shift),
        .i_load    (w_load),
        .i_ready   (bus.ready),
        .o_data    (w_data),
        .o_valid   (w_valid),
        .o_overrun (w_overrun)
    );

    assign bus.data_out  = w_data;
    assign bus.valid     = w_valid;
    assign bus.frame_err = r_frame_err;
    assign bus.overrun   = w_overrun;
endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- Receive-side counterpart of the team's parallel-to-serial buffer.
- Accepts a one-bit-per-clock serial stream and checks its framing: a start bit, DATA_W data bits MSB-first, then a stop bit.
- Reassembles each frame into a DATA_W-bit word and presents it on a valid/ready holding register to downstream logic.
- Sits between the serial link and the word-level consumer; flags framing errors and overruns.

Parameters:
- DATA_W, 4, data bits per frame (MSB first on the line).

Ports:
- clk  input  1  system clock; all sampling on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  receiver enable; 0 = idle/abort.
- data_in  input  1  serial line; idles high (1).
- ready  input  1  downstream accepts data_out when valid=1.
- data_out  output  DATA_W  last good received word.
- valid  output  1  data_out holds an unconsumed word.
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: good word dropped because holding register full.

Interface decision: one clock (clk); reset rst_n is asynchronous, active-low.

Behaviour:
- Reset (rst_n=0, any time, including mid-frame): FSM to IDLE, bit counter=0, shift register=0, data_out=0, valid=0, frame_err=0, overrun=0.
- FSM states:
  - IDLE -> DATA when ena=1 and data_in=0 (start bit).
  - DATA: samples one bit per clk into the shift register, MSB first. Counter runs 0..DATA_W-1. At count DATA_W-1 it goes to STOP.
  - STOP: samples the stop bit, then returns to IDLE.
- ena=0 in DATA or STOP: return to IDLE at the next edge. The partial word is discarded; no error and no valid.
- Stop bit = 1 (good frame):
  - If valid=0, or valid=1 and ready=1 in the same cycle: load data_out with the shifted word; valid=1 from the next cycle.
  - Otherwise: word dropped, overrun=1 for one cycle, data_out and valid unchanged.
- Stop bit = 0 (bad frame): frame_err=1 for one cycle. The word is discarded. That 0 is NOT treated as a new start bit.
- Handshake: valid stays high and data_out stays stable until a cycle with ready=1. Valid then clears at the next edge, unless a new word loads on that same edge, in which case valid stays 1 with the new data.
- Latency: start bit sampled at edge E0; data bits sampled at E1..E_DATA_W; stop bit at E_DATA_W+1. valid/data_out update at E_DATA_W+1, i.e. 5 cycles after E0 for DATA_W=4.
- Back-to-back frames with no idle gap are supported. IDLE detects a start bit on the cycle right after STOP, giving a minimum frame period of DATA_W+2 clocks.
- Counter width: clog2(DATA_W). No wrap beyond DATA_W-1.
- Simultaneous events: frame_err and overrun can never be set in the same cycle. ready arriving while valid=0 is ignored.

Decomposition:
- Package serial_pkg: FSM state enum (IDLE, DATA, STOP) and default DATA_W constant. The package is shared with the transmit buffer for framing agreement.
- One natural sub-module: rx_hold. It holds the valid/ready output register plus overrun detection. Inputs: word, load strobe, ready.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-frame -> data_out=0, valid=0, flags=0 immediately. After release, the next frame is received normally.
- Single frame with ready=1: line 1,0,1,0,1,0,1 -> data_out=4'b1010; valid=1 at E0+5, cleared at E0+6.
- Back-to-back frames 4'b0001 then 4'b1111, no gap, ready=1 -> two valid pulses exactly 6 cycles apart, words correct in order.
- Bad stop: start, 4'b0110, stop=0 -> frame_err pulse 1 cycle, valid stays 0. A following good frame 4'b0101 arrives -> data_out=4'b0101, no spurious start detected from the bad stop bit.
- Overrun: ready=0, frames 4'b1100 then 4'b0011 -> data_out stays 4'b1100 with valid=1, overrun pulses at the second stop. Then raise ready=1 -> valid drops next edge.
- ena abort: drop ena for 1 cycle after 2 data bits -> no valid, no frame_err. A re-enabled full frame 4'b1001 is received correctly.
